// File: rtl/fft_pkg.sv
// Shared FFT constants, read-FSM encoding and the bit-reverse helper.
package fft_pkg;

   localparam int unsigned NB_DATA_DEF = 12;
   localparam int unsigned N_FFT_DEF   = 32;
   localparam int unsigned LOG2_N_DEF  = 5;

   // Widest index the bit-reverse helper handles.
   localparam int unsigned BITREV_W    = 16;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_READ = 1'b1
   } rd_state_e;

   // Reverse the low nbits of x; the result is right-aligned.
   function automatic logic [BITREV_W-1:0] bitrev(input logic [BITREV_W-1:0] x,
                                                  input int unsigned nbits);
      logic [BITREV_W-1:0] full_rev;
      full_rev = {<<{x}};
      return full_rev >> (BITREV_W - nbits);
   endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank frame store: one write port, one registered read port.
module fft_pingpong_ram
   import fft_pkg::*;
#(
   parameter int unsigned NB_DATA = NB_DATA_DEF,
   parameter int unsigned N_FFT   = N_FFT_DEF,
   parameter int unsigned LOG2_N  = LOG2_N_DEF
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_we,
   input  logic                   i_wr_bank,
   input  logic [LOG2_N-1:0]      i_wr_addr,
   input  logic [2*NB_DATA-1:0]   i_wr_data,
   input  logic                   i_re,
   input  logic                   i_rd_bank,
   input  logic [LOG2_N-1:0]      i_rd_addr,
   output logic [2*NB_DATA-1:0]   o_rd_data
);

   localparam int unsigned W = 2 * NB_DATA;

   logic [W-1:0] mem_q [2*N_FFT];
   logic [W-1:0] rd_data_q;
   logic [W-1:0] rd_data_d;

   // Storage write; contents are never cleared.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_q[{i_wr_bank, i_wr_addr}] <= i_wr_data;
      end
   end

   // Read data register loads only when a read is requested.
   always_comb begin
      rd_data_d = rd_data_q;
      if (i_re) begin
         rd_data_d = mem_q[{i_rd_bank, i_rd_addr}];
      end
   end

   // Read register with reset so the downstream output starts at zero.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign o_rd_data = rd_data_q;

endmodule

// File: rtl/fft_bin_reorder.sv
// Converts bit-reversed serial FFT bins to natural order using a ping-pong store.
module fft_bin_reorder
   import fft_pkg::*;
#(
   parameter int unsigned NB_DATA = NB_DATA_DEF,
   parameter int unsigned N_FFT   = N_FFT_DEF,
   parameter int unsigned LOG2_N  = LOG2_N_DEF
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_enable,
   input  logic                   i_valid,
   input  logic [2*NB_DATA-1:0]   i_din,
   output logic [2*NB_DATA-1:0]   o_dout,
   output logic                   o_valid,
   output logic [LOG2_N-1:0]      o_bin_idx,
   output logic                   o_frame_start
);

   localparam logic [LOG2_N-1:0] LAST_BIN = LOG2_N'(N_FFT - 1);

   rd_state_e         state_q, state_d;
   logic [LOG2_N-1:0] wr_cnt_q, wr_cnt_d;
   logic              wr_bank_q, wr_bank_d;
   logic [1:0]        bank_full_q, bank_full_d;
   logic              rd_bank_q, rd_bank_d;
   logic [LOG2_N-1:0] rd_cnt_q, rd_cnt_d;
   logic              o_valid_q, o_valid_d;
   logic [LOG2_N-1:0] o_bin_idx_q, o_bin_idx_d;
   logic              o_frame_start_q, o_frame_start_d;

   logic              accept_c;
   logic              frame_done_c;
   logic              rd_last_c;
   logic [1:0]        full_now_c;
   logic              ram_re_c;
   logic [LOG2_N-1:0] wr_addr_c;

   // Frame completion and bank occupancy including this cycle's completion.
   always_comb begin
      accept_c     = i_enable & i_valid;
      frame_done_c = accept_c && (wr_cnt_q == LAST_BIN);
      rd_last_c    = (state_q == RD_READ) && (rd_cnt_q == LAST_BIN);
      full_now_c   = bank_full_q;
      if (frame_done_c) begin
         full_now_c[wr_bank_q] = 1'b1;
      end
      wr_addr_c    = LOG2_N'(bitrev(BITREV_W'(wr_cnt_q), LOG2_N));
   end

   // Read FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= RD_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Read FSM next state: chain straight into the other bank if it is already full.
   always_comb begin
      state_d = state_q;
      if (i_enable) begin
         case (state_q)
            RD_IDLE: if (full_now_c[rd_bank_q]) state_d = RD_READ;
            RD_READ: if (rd_last_c) state_d = full_now_c[~rd_bank_q] ? RD_READ : RD_IDLE;
            default: state_d = RD_IDLE;
         endcase
      end
   end

   // Read FSM outputs: next values of the registered output flags.
   always_comb begin
      o_valid_d       = o_valid_q;
      o_bin_idx_d     = o_bin_idx_q;
      o_frame_start_d = o_frame_start_q;
      ram_re_c        = 1'b0;
      if (i_enable) begin
         o_valid_d       = (state_q == RD_READ);
         o_bin_idx_d     = rd_cnt_q;
         o_frame_start_d = (state_q == RD_READ) && (rd_cnt_q == '0);
         ram_re_c        = (state_q == RD_READ);
      end
   end

   // Write/read counters, bank pointers and full flags.
   always_comb begin
      wr_cnt_d    = wr_cnt_q;
      wr_bank_d   = wr_bank_q;
      rd_cnt_d    = rd_cnt_q;
      rd_bank_d   = rd_bank_q;
      bank_full_d = bank_full_q;
      if (accept_c) begin
         wr_cnt_d = wr_cnt_q + LOG2_N'(1);
         if (frame_done_c) begin
            wr_bank_d = ~wr_bank_q;
         end
      end
      if (i_enable) begin
         bank_full_d = full_now_c;
         if (state_q == RD_READ) begin
            rd_cnt_d = rd_cnt_q + LOG2_N'(1);
            if (rd_last_c) begin
               bank_full_d[rd_bank_q] = 1'b0;
               rd_bank_d              = ~rd_bank_q;
            end
         end
      end
   end

   // Datapath and output registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_cnt_q        <= '0;
         wr_bank_q       <= 1'b0;
         rd_cnt_q        <= '0;
         rd_bank_q       <= 1'b0;
         bank_full_q     <= '0;
         o_valid_q       <= 1'b0;
         o_bin_idx_q     <= '0;
         o_frame_start_q <= 1'b0;
      end else begin
         wr_cnt_q        <= wr_cnt_d;
         wr_bank_q       <= wr_bank_d;
         rd_cnt_q        <= rd_cnt_d;
         rd_bank_q       <= rd_bank_d;
         bank_full_q     <= bank_full_d;
         o_valid_q       <= o_valid_d;
         o_bin_idx_q     <= o_bin_idx_d;
         o_frame_start_q <= o_frame_start_d;
      end
   end

   fft_pingpong_ram #(
      .NB_DATA (NB_DATA),
      .N_FFT   (N_FFT),
      .LOG2_N  (LOG2_N)
   ) u_ram (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_we      (accept_c & ~i_rst),
      .i_wr_bank (wr_bank_q),
      .i_wr_addr (wr_addr_c),
      .i_wr_data (i_din),
      .i_re      (ram_re_c),
      .i_rd_bank (rd_bank_q),
      .i_rd_addr (rd_cnt_q),
      .o_rd_data (o_dout)
   );

   assign o_valid       = o_valid_q;
   assign o_bin_idx     = o_bin_idx_q;
   assign o_frame_start = o_frame_start_q;

endmodule

// File: tb/tb_fft_bin_reorder.sv
// Bench for fft_bin_reorder: randomized frames checked against an index-reversal model.
module tb_fft_bin_reorder;

   localparam int NB = 12;
   localparam int N  = 32;
   localparam int LG = 5;

   logic            i_clk = 1'b0;
   logic            i_rst;
   logic            i_enable;
   logic            i_valid;
   logic [2*NB-1:0] i_din;
   logic [2*NB-1:0] o_dout;
   logic            o_valid;
   logic [LG-1:0]   o_bin_idx;
   logic            o_frame_start;

   fft_bin_reorder #(.NB_DATA(NB), .N_FFT(N), .LOG2_N(LG)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_enable      (i_enable),
      .i_valid       (i_valid),
      .i_din         (i_din),
      .o_dout        (o_dout),
      .o_valid       (o_valid),
      .o_bin_idx     (o_bin_idx),
      .o_frame_start (o_frame_start)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [2*NB-1:0] d;
      logic [LG-1:0]   idx;
      logic            fs;
      int              ec;
   } obs_t;

   obs_t            obs_q[$];
   logic [2*NB-1:0] stim [4*N];
   int              n_checks = 0;
   int              n_errors = 0;
   int              en_cyc   = 0;
   logic            mon_en;
   logic            mon_rst;

   // Reference reordering: natural bin j holds the sample that arrived j-th in reversed index order.
   function automatic int bitrev5(input int x);
      int r = 0;
      for (int i = 0; i < LG; i++) r = r * 2 + ((x >> i) & 1);
      return r;
   endfunction

   // Monitor: records one entry per enabled, non-reset edge that presents a valid bin.
   always @(posedge i_clk) begin
      mon_en  = i_enable;
      mon_rst = i_rst;
      if (mon_en) en_cyc++;
      #1;
      if (mon_en && !mon_rst && o_valid === 1'b1) begin
         obs_q.push_back('{d: o_dout, idx: o_bin_idx, fs: o_frame_start, ec: en_cyc});
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst   = 1'b1;
      i_valid = 1'b0;
      tick();
      i_rst   = 1'b0;
      obs_q.delete();
   endtask

   // Drives N samples starting at stim[base]; gap_mode 0 none, 1 alternate, 2 random.
   task automatic send_frame(input int base, input int gap_mode);
      for (int k = 0; k < N; k++) begin
         if (gap_mode == 1 && k > 0) begin
            i_valid = 1'b0;
            i_din   = 24'($urandom);
            tick();
         end
         while (gap_mode == 2 && $urandom_range(0, 3) == 0) begin
            i_valid = 1'b0;
            i_din   = 24'($urandom);
            tick();
         end
         i_valid = 1'b1;
         i_din   = stim[base + k];
         tick();
      end
      i_valid = 1'b0;
   endtask

   task automatic test_reset();
      i_enable = 1'b0;
      i_rst    = 1'b1;
      tick();
      n_checks++;
      if (o_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
      n_checks++;
      if (o_dout !== '0) begin n_errors++; $display("FAIL reset_dout: got %h expected 0", o_dout); end
      n_checks++;
      if (o_bin_idx !== '0) begin n_errors++; $display("FAIL reset_idx: got %0d expected 0", o_bin_idx); end
      n_checks++;
      if (o_frame_start !== 1'b0) begin n_errors++; $display("FAIL reset_fs: got %b expected 0", o_frame_start); end
      i_rst    = 1'b0;
      i_enable = 1'b1;
      repeat (5) tick();
      n_checks++;
      if (o_valid !== 1'b0) begin n_errors++; $display("FAIL idle_valid: got %b expected 0", o_valid); end
   endtask

   task automatic test_single_frame();
      do_reset();
      for (int k = 0; k < N; k++) stim[k] = 24'(k);
      send_frame(0, 0);
      n_checks++;
      if (o_valid !== 1'b0) begin n_errors++; $display("FAIL latency_early: got %b expected 0", o_valid); end
      tick();
      n_checks++;
      if (o_valid !== 1'b1 || o_frame_start !== 1'b1 || o_bin_idx !== '0 || o_dout !== '0) begin
         n_errors++;
         $display("FAIL latency_first: got v=%b fs=%b idx=%0d d=%h expected v=1 fs=1 idx=0 d=0",
                  o_valid, o_frame_start, o_bin_idx, o_dout);
      end
      repeat (N + 4) tick();
      n_checks++;
      if (obs_q.size() != N) begin
         n_errors++; $display("FAIL single_count: got %0d expected %0d", obs_q.size(), N);
      end
      for (int j = 0; j < obs_q.size() && j < N; j++) begin
         n_checks++;
         if (obs_q[j].d !== 24'(bitrev5(j)) || obs_q[j].idx !== LG'(j) || obs_q[j].fs !== (j == 0) ||
             obs_q[j].ec !== obs_q[0].ec + j) begin
            n_errors++;
            $display("FAIL single_bin%0d: got d=%h idx=%0d fs=%b expected d=%h idx=%0d fs=%b",
                     j, obs_q[j].d, obs_q[j].idx, obs_q[j].fs, 24'(bitrev5(j)), j, j == 0);
         end
      end
      n_checks++;
      if (o_valid !== 1'b0) begin n_errors++; $display("FAIL single_tail_valid: got %b expected 0", o_valid); end
   endtask

   // Sends nframes frames with the given gap pattern and checks the natural-order stream.
   task automatic test_stream(input string name, input int nframes, input int gap_mode, input bit rand_data);
      int budget;
      int total;
      total = nframes * N;
      for (int f = 0; f < nframes; f++)
         for (int k = 0; k < N; k++)
            stim[f * N + k] = rand_data ? 24'($urandom) : 24'(k + f * 'h100);
      for (int f = 0; f < nframes; f++) send_frame(f * N, gap_mode);
      budget = 0;
      while (obs_q.size() < total && budget < 4 * N) begin
         tick();
         budget++;
      end
      repeat (4) tick();
      n_checks++;
      if (obs_q.size() != total) begin
         n_errors++; $display("FAIL %s_count: got %0d expected %0d", name, obs_q.size(), total);
      end
      for (int j = 0; j < obs_q.size() && j < total; j++) begin
         int b;
         logic [2*NB-1:0] exp_d;
         b     = j % N;
         exp_d = stim[(j / N) * N + bitrev5(b)];
         n_checks++;
         if (obs_q[j].d !== exp_d || obs_q[j].idx !== LG'(b) || obs_q[j].fs !== (b == 0)) begin
            n_errors++;
            $display("FAIL %s_bin%0d: got d=%h idx=%0d fs=%b expected d=%h idx=%0d fs=%b",
                     name, j, obs_q[j].d, obs_q[j].idx, obs_q[j].fs, exp_d, b, b == 0);
         end
         if (j > 0 && (b > 0 || gap_mode == 0)) begin
            n_checks++;
            if (obs_q[j].ec !== obs_q[j - 1].ec + 1) begin
               n_errors++;
               $display("FAIL %s_gap%0d: got cycle %0d expected %0d", name, j, obs_q[j].ec, obs_q[j - 1].ec + 1);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      test_stream("b2b", 2, 0, 1'b0);
   endtask

   task automatic test_valid_gaps();
      do_reset();
      test_stream("alt_gap", 1, 1, 1'b0);
      do_reset();
      test_stream("rnd_gap", 3, 2, 1'b1);
   endtask

   task automatic test_enable_freeze();
      int budget;
      logic [2*NB-1:0] exp10;
      do_reset();
      for (int k = 0; k < N; k++) stim[k] = 24'($urandom);
      exp10 = stim[bitrev5(10)];
      send_frame(0, 0);
      budget = 0;
      while (!(o_valid === 1'b1 && o_bin_idx === LG'(10)) && budget < 3 * N) begin
         tick();
         budget++;
      end
      n_checks++;
      if (budget >= 3 * N) begin n_errors++; $display("FAIL freeze_reach: got timeout expected bin 10"); end
      i_enable = 1'b0;
      i_valid  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         i_din = 24'($urandom);
         tick();
         n_checks++;
         if (o_valid !== 1'b1 || o_bin_idx !== LG'(10) || o_dout !== exp10 || o_frame_start !== 1'b0) begin
            n_errors++;
            $display("FAIL freeze_hold%0d: got v=%b idx=%0d d=%h fs=%b expected v=1 idx=10 d=%h fs=0",
                     c, o_valid, o_bin_idx, o_dout, o_frame_start, exp10);
         end
      end
      i_valid  = 1'b0;
      i_enable = 1'b1;
      repeat (N) tick();
      n_checks++;
      if (obs_q.size() != N) begin n_errors++; $display("FAIL freeze_count: got %0d expected %0d", obs_q.size(), N); end
      for (int j = 0; j < obs_q.size() && j < N; j++) begin
         n_checks++;
         if (obs_q[j].d !== stim[bitrev5(j)] || obs_q[j].idx !== LG'(j) || obs_q[j].ec !== obs_q[0].ec + j) begin
            n_errors++;
            $display("FAIL freeze_bin%0d: got d=%h idx=%0d expected d=%h idx=%0d",
                     j, obs_q[j].d, obs_q[j].idx, stim[bitrev5(j)], j);
         end
      end
   endtask

   task automatic test_reset_partial();
      do_reset();
      for (int k = 0; k < 20; k++) begin
         i_valid = 1'b1;
         i_din   = 24'($urandom);
         tick();
      end
      i_valid = 1'b0;
      do_reset();
      repeat (2 * N) tick();
      n_checks++;
      if (obs_q.size() != 0 || o_valid !== 1'b0) begin
         n_errors++; $display("FAIL partial_no_out: got %0d bins expected 0", obs_q.size());
      end
      test_stream("after_partial", 1, 0, 1'b0);
   endtask

   task automatic test_reset_mid_output();
      int budget;
      do_reset();
      for (int k = 0; k < N; k++) stim[k] = 24'($urandom);
      send_frame(0, 0);
      budget = 0;
      while (!(o_valid === 1'b1 && o_bin_idx === LG'(5)) && budget < 3 * N) begin
         tick();
         budget++;
      end
      n_checks++;
      if (budget >= 3 * N) begin n_errors++; $display("FAIL midrst_reach: got timeout expected bin 5"); end
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      obs_q.delete();
      n_checks++;
      if (o_valid !== 1'b0 || o_dout !== '0 || o_bin_idx !== '0) begin
         n_errors++;
         $display("FAIL midrst_clear: got v=%b d=%h idx=%0d expected v=0 d=0 idx=0", o_valid, o_dout, o_bin_idx);
      end
      repeat (2 * N) tick();
      n_checks++;
      if (obs_q.size() != 0) begin n_errors++; $display("FAIL midrst_no_more: got %0d bins expected 0", obs_q.size()); end
   endtask

   initial begin
      i_rst    = 1'b0;
      i_enable = 1'b0;
      i_valid  = 1'b0;
      i_din    = '0;
      tick();
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_valid_gaps();
      test_enable_freeze();
      test_reset_partial();
      test_reset_mid_output();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
